// File: rtl/auth_lock_ctrl.sv
// auth_lock_ctrl: sequencing controller for a setter/guesser code comparator.
// It stores the setter's code, latches each guess, fires the external
// comparator for one cycle, and times the unlocked window and the lockout
// that follows too many failed attempts.
module auth_lock_ctrl #(
  parameter int CODE_W      = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 16,
  parameter int OPEN_CYCLES = 8,
  localparam int TRY_W      = $clog2(MAX_TRIES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] set_code,
  input  logic              set_btn,
  input  logic [CODE_W-1:0] guess,
  input  logic              submit_btn,
  output logic [CODE_W-1:0] code_out,
  output logic [CODE_W-1:0] guess_out,
  output logic              cmp_en,
  input  logic              match_in,
  output logic              unlocked,
  output logic              denied,
  output logic              alarm,
  output logic [TRY_W-1:0]  tries_left,
  output logic [2:0]        state
);

  // One shared counter times both OPEN and LOCKOUT, so it is sized for the
  // longer of the two windows.
  localparam int MAX_WIN = (LOCK_CYCLES > OPEN_CYCLES) ? LOCK_CYCLES : OPEN_CYCLES;
  localparam int CNT_W   = $clog2(MAX_WIN + 1);

  localparam logic [CNT_W-1:0] OPEN_LAST = CNT_W'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [TRY_W-1:0] TRY_MAX   = TRY_W'(MAX_TRIES);
  localparam logic [TRY_W-1:0] TRY_ONE   = TRY_W'(1);

  typedef enum logic [2:0] {
    S_EMPTY   = 3'd0,
    S_ARMED   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_DENY    = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [CODE_W-1:0]  guess_q, guess_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               set_prev_q, sub_prev_q;
  logic               set_edge, sub_edge;

  // A held button must count once, so only the 0->1 transition is an event.
  assign set_edge = set_btn & ~set_prev_q;
  assign sub_edge = submit_btn & ~sub_prev_q;

  // Button history is tracked in every state so an edge swallowed during
  // DENY or LOCKOUT cannot reappear later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_prev_q <= 1'b0;
      sub_prev_q <= 1'b0;
    end else begin
      set_prev_q <= set_btn;
      sub_prev_q <= submit_btn;
    end
  end

  // State, stored code, latched guess, attempt budget and window counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      code_q  <= '0;
      guess_q <= '0;
      tries_q <= TRY_MAX;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      guess_q <= guess_d;
      tries_q <= tries_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; everything holds unless a state handler changes it.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    guess_d = guess_q;
    tries_d = tries_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_EMPTY: begin
        if (set_edge) begin
          code_d  = set_code;
          tries_d = TRY_MAX;
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        // Submit wins over a simultaneous set; rekeying here is not allowed.
        if (sub_edge) begin
          guess_d = guess;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (match_in) begin
          tries_d = TRY_MAX;
          cnt_d   = '0;
          state_d = S_OPEN;
        end else if (tries_q > TRY_ONE) begin
          tries_d = tries_q - 1'b1;
          state_d = S_DENY;
        end else begin
          tries_d = '0;
          cnt_d   = '0;
          state_d = S_LOCKOUT;
        end
      end
      S_DENY: begin
        state_d = S_ARMED;
      end
      S_OPEN: begin
        // Rekeying takes priority over the window running out.
        if (set_edge) begin
          code_d  = set_code;
          state_d = S_ARMED;
        end else if (cnt_q == OPEN_LAST) begin
          state_d = S_ARMED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LOCKOUT: begin
        if (cnt_q == LOCK_LAST) begin
          tries_d = TRY_MAX;
          state_d = S_ARMED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
  end

  assign code_out   = code_q;
  assign guess_out  = guess_q;
  assign tries_left = tries_q;
  assign state      = state_q;
  assign cmp_en     = (state_q == S_CHECK);
  assign unlocked   = (state_q == S_OPEN);
  assign denied     = (state_q == S_DENY);
  assign alarm      = (state_q == S_LOCKOUT);

endmodule

// File: tb/tb_auth_lock_ctrl.sv
// Testbench for auth_lock_ctrl: directed scenarios with literal expectations
// plus a long random run, all checked every cycle against a timer-based model.
module tb_auth_lock_ctrl;

  localparam int CODE_W      = 4;
  localparam int MAX_TRIES   = 3;
  localparam int LOCK_CYCLES = 16;
  localparam int OPEN_CYCLES = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [CODE_W-1:0] set_code = '0;
  logic              set_btn = 1'b0;
  logic [CODE_W-1:0] guess = '0;
  logic              submit_btn = 1'b0;
  logic [CODE_W-1:0] code_out;
  logic [CODE_W-1:0] guess_out;
  logic              cmp_en;
  logic              match_in;
  logic              unlocked;
  logic              denied;
  logic              alarm;
  logic [1:0]        tries_left;
  logic [2:0]        dut_state;

  int n_compared = 0;
  int n_failed   = 0;

  auth_lock_ctrl #(
    .CODE_W(CODE_W), .MAX_TRIES(MAX_TRIES),
    .LOCK_CYCLES(LOCK_CYCLES), .OPEN_CYCLES(OPEN_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .set_code(set_code), .set_btn(set_btn),
    .guess(guess), .submit_btn(submit_btn),
    .code_out(code_out), .guess_out(guess_out),
    .cmp_en(cmp_en), .match_in(match_in),
    .unlocked(unlocked), .denied(denied), .alarm(alarm),
    .tries_left(tries_left), .state(dut_state)
  );

  // External combinational comparator.
  assign match_in = cmp_en && (code_out == guess_out);

  always #5 clk = ~clk;

  // Model: phases are represented by pending flags and countdown timers.
  bit        m_has_code, m_check, m_deny, m_prev_set, m_prev_sub;
  int        m_open_left, m_lock_left, m_tries;
  logic [3:0] m_code, m_guess;

  // Model update, evaluated on the same edges that clock the design.
  always @(posedge clk or negedge rst_n) begin
    bit se, be;
    if (!rst_n) begin
      m_has_code = 0; m_check = 0; m_deny = 0;
      m_prev_set = 0; m_prev_sub = 0;
      m_open_left = 0; m_lock_left = 0;
      m_tries = MAX_TRIES; m_code = '0; m_guess = '0;
    end else begin
      se = set_btn && !m_prev_set;
      be = submit_btn && !m_prev_sub;
      m_prev_set = set_btn;
      m_prev_sub = submit_btn;
      if (!m_has_code) begin
        if (se) begin
          m_has_code = 1; m_code = set_code; m_tries = MAX_TRIES;
        end
      end else if (m_check) begin
        m_check = 0;
        if (m_code == m_guess) begin
          m_open_left = OPEN_CYCLES; m_tries = MAX_TRIES;
        end else if (m_tries > 1) begin
          m_tries = m_tries - 1; m_deny = 1;
        end else begin
          m_tries = 0; m_lock_left = LOCK_CYCLES;
        end
      end else if (m_open_left > 0) begin
        if (se) begin
          m_code = set_code; m_open_left = 0;
        end else begin
          m_open_left = m_open_left - 1;
        end
      end else if (m_deny) begin
        m_deny = 0;
      end else if (m_lock_left > 0) begin
        m_lock_left = m_lock_left - 1;
        if (m_lock_left == 0) m_tries = MAX_TRIES;
      end else if (be) begin
        m_guess = guess; m_check = 1;
      end
    end
  end

  function automatic int exp_state();
    if (!m_has_code)     return 0;
    if (m_check)         return 2;
    if (m_open_left > 0) return 3;
    if (m_deny)          return 4;
    if (m_lock_left > 0) return 5;
    return 1;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    n_compared++;
    if (act != exp) begin
      n_failed++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int es;
    es = exp_state();
    checkOutput("state",      int'(dut_state),  es);
    checkOutput("code_out",   int'(code_out),   int'(m_code));
    checkOutput("guess_out",  int'(guess_out),  int'(m_guess));
    checkOutput("tries_left", int'(tries_left), m_tries);
    checkOutput("cmp_en",     int'(cmp_en),     int'(es == 2));
    checkOutput("unlocked",   int'(unlocked),   int'(es == 3));
    checkOutput("denied",     int'(denied),     int'(es == 4));
    checkOutput("alarm",      int'(alarm),      int'(es == 5));
  end

  // Drive one cycle of inputs, returning at the following falling edge.
  task automatic applyStimulus(input logic s, input logic [3:0] sc,
                               input logic b, input logic [3:0] g);
    set_btn = s; set_code = sc; submit_btn = b; guess = g;
    @(negedge clk);
  endtask

  task automatic tryGuess(input logic [3:0] sc, input logic [3:0] g);
    applyStimulus(1'b0, sc, 1'b1, g);
    applyStimulus(1'b0, sc, 1'b0, g);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_state"},    int'(dut_state),  0);
    checkOutput({tag, "_code"},     int'(code_out),   0);
    checkOutput({tag, "_guess"},    int'(guess_out),  0);
    checkOutput({tag, "_cmp_en"},   int'(cmp_en),     0);
    checkOutput({tag, "_unlocked"}, int'(unlocked),   0);
    checkOutput({tag, "_denied"},   int'(denied),     0);
    checkOutput({tag, "_alarm"},    int'(alarm),      0);
    checkOutput({tag, "_tries"},    int'(tries_left), 3);
  endtask

  task automatic asyncReset(input string tag);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkResetValues(tag);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int ce, ul, al;
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkResetValues("reset");

    // Submit before any code is set does nothing.
    applyStimulus(1'b0, 4'h0, 1'b1, 4'hA);
    applyStimulus(1'b0, 4'h0, 1'b0, 4'hA);
    checkOutput("empty_submit_state", int'(dut_state), 0);

    // Set the code.
    applyStimulus(1'b1, 4'b1010, 1'b0, 4'h0);
    checkOutput("set_state", int'(dut_state), 1);
    checkOutput("set_code",  int'(code_out),  4'hA);
    checkOutput("set_tries", int'(tries_left), 3);
    applyStimulus(1'b0, 4'hA, 1'b0, 4'h0);

    // Correct guess: one CHECK cycle then eight OPEN cycles.
    applyStimulus(1'b0, 4'hA, 1'b1, 4'hA);
    checkOutput("latency_check", int'(dut_state), 2);
    ce = int'(cmp_en); ul = 0;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b0, 4'hA, 1'b0, 4'hA);
      ce += int'(cmp_en); ul += int'(unlocked);
    end
    checkOutput("open_cmp_en_count", ce, 1);
    checkOutput("open_unlocked_count", ul, 8);
    checkOutput("open_end_state", int'(dut_state), 1);

    // Three wrong guesses lead to lockout.
    tryGuess(4'hA, 4'h5);
    checkOutput("fail1_state",  int'(dut_state), 4);
    checkOutput("fail1_denied", int'(denied), 1);
    checkOutput("fail1_tries",  int'(tries_left), 2);
    applyStimulus(1'b0, 4'hA, 1'b0, 4'h5);
    tryGuess(4'hA, 4'h5);
    checkOutput("fail2_state", int'(dut_state), 4);
    checkOutput("fail2_tries", int'(tries_left), 1);
    applyStimulus(1'b0, 4'hA, 1'b0, 4'h5);
    tryGuess(4'hA, 4'h5);
    checkOutput("fail3_state", int'(dut_state), 5);
    checkOutput("fail3_tries", int'(tries_left), 0);
    al = int'(alarm); ce = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 4'hA, (i == 3), 4'hA);
      al += int'(alarm); ce += int'(cmp_en);
    end
    checkOutput("lock_alarm_count", al, 16);
    checkOutput("lock_cmp_en_count", ce, 0);
    checkOutput("lock_end_state", int'(dut_state), 1);
    checkOutput("lock_end_tries", int'(tries_left), 3);

    // Rekey while open.
    tryGuess(4'hA, 4'hA);
    checkOutput("rekey_open", int'(dut_state), 3);
    applyStimulus(1'b1, 4'h3, 1'b0, 4'hA);
    checkOutput("rekey_state", int'(dut_state), 1);
    checkOutput("rekey_code",  int'(code_out), 3);
    applyStimulus(1'b0, 4'h3, 1'b0, 4'hA);
    tryGuess(4'h3, 4'hA);
    checkOutput("rekey_old_fails", int'(dut_state), 4);
    applyStimulus(1'b0, 4'h3, 1'b0, 4'hA);
    tryGuess(4'h3, 4'h3);
    checkOutput("rekey_new_opens", int'(dut_state), 3);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 4'h3, 1'b0, 4'h3);

    // Held submit gives a single attempt.
    ce = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 4'h3, 1'b1, 4'h5);
      ce += int'(cmp_en);
    end
    applyStimulus(1'b0, 4'h3, 1'b0, 4'h5);
    checkOutput("held_cmp_en_count", ce, 1);
    checkOutput("held_tries", int'(tries_left), 2);

    // Simultaneous set and submit: submit taken, code unchanged.
    applyStimulus(1'b1, 4'hC, 1'b1, 4'h3);
    checkOutput("simul_check", int'(dut_state), 2);
    applyStimulus(1'b0, 4'hC, 1'b0, 4'h3);
    checkOutput("simul_open", int'(dut_state), 3);
    checkOutput("simul_code", int'(code_out), 3);

    // Asynchronous reset in the middle of OPEN.
    applyStimulus(1'b0, 4'hC, 1'b0, 4'h3);
    asyncReset("rst_open");

    // Asynchronous reset in the middle of LOCKOUT.
    applyStimulus(1'b1, 4'hA, 1'b0, 4'h0);
    applyStimulus(1'b0, 4'hA, 1'b0, 4'h0);
    for (int k = 0; k < 3; k++) begin
      tryGuess(4'hA, 4'h6);
      applyStimulus(1'b0, 4'hA, 1'b0, 4'h6);
    end
    applyStimulus(1'b0, 4'hA, 1'b0, 4'h6);
    checkOutput("pre_rst_alarm", int'(alarm), 1);
    asyncReset("rst_lock");

    // Random traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        applyStimulus($urandom_range(0, 7) == 0, 4'($urandom),
                      $urandom_range(0, 3) == 0,
                      ($urandom_range(0, 1) == 1) ? m_code : 4'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule

// File: doc/auth_lock_ctrl.md
Name: auth_lock_ctrl

Overview:
- Sequencing controller for the 4-bit setter/guesser code comparator.
- Holds the setter's code and presents code and guess to the external combinational comparator.
- Fires the comparator's enable ("button") for exactly one cycle per guess attempt.
- Counts failed attempts, enforces a timed lockout, and times the unlocked window.

Parameters:
- CODE_W, 4, width of the code and the guess.
- MAX_TRIES, 3, failed attempts allowed before lockout (must be ≥1).
- LOCK_CYCLES, 16, lockout duration in clocks (must be ≥1).
- OPEN_CYCLES, 8, unlocked window duration in clocks (must be ≥1).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- set_code  in  CODE_W  code to store on a set request.
- set_btn  in  1  level; its rising edge is a set request.
- guess  in  CODE_W  guesser code, sampled on a submit.
- submit_btn  in  1  level; its rising edge is a guess attempt.
- code_out  out  CODE_W  stored code, drives comparator setter inputs.
- guess_out  out  CODE_W  latched guess, drives comparator guesser inputs.
- cmp_en  out  1  comparator enable (button).
- match_in  in  1  comparator matched output, combinational from code_out/guess_out/cmp_en.
- unlocked  out  1  high throughout OPEN.
- denied  out  1  one-cycle pulse on each failed attempt.
- alarm  out  1  high throughout LOCKOUT.
- tries_left  out  2  remaining attempts; width is clog2(MAX_TRIES+1).
- state  out  3  current state encoding.

Behaviour:
- Reset (async assert, sync release): state=EMPTY; code_out=0; guess_out=0; cmp_en=0; unlocked=0; denied=0; alarm=0; tries_left=MAX_TRIES; edge-detect history registers=0; counters=0.
- Edge detect: register previous set_btn and submit_btn; act only on 0→1 transitions. A button held high produces one event.
- State encodings: EMPTY=0, ARMED=1, CHECK=2, OPEN=3, DENY=4, LOCKOUT=5. Codes 6 and 7 return to EMPTY on the next clock.
- EMPTY:
  - Set edge → latch set_code into code_out, tries_left=MAX_TRIES, go to ARMED.
  - Submit ignored.
- ARMED:
  - Submit edge → latch guess into guess_out, go to CHECK.
  - Set edge ignored (no rekey while locked).
  - Submit and set on the same cycle: submit taken.
- CHECK:
  - Lasts exactly one cycle; cmp_en=1 only in this state.
  - match_in is sampled at the end of the CHECK cycle.
  - match_in=1 → OPEN, tries_left=MAX_TRIES, open counter=0.
  - match_in=0 and tries_left>1 → DENY, tries_left decrements.
  - match_in=0 and tries_left==1 → LOCKOUT, tries_left=0, lock counter=0.
- DENY: denied=1 for one cycle, then ARMED. Button edges during DENY are dropped.
- OPEN:
  - unlocked=1; counter increments each cycle.
  - Set edge → latch new code, go to ARMED (rekey); this has priority over timeout.
  - Counter reaches OPEN_CYCLES-1 → ARMED.
  - Submit ignored.
- LOCKOUT:
  - alarm=1; all button edges dropped.
  - Counter reaches LOCK_CYCLES-1 → ARMED, tries_left=MAX_TRIES.
- Latency: submit edge seen at rising edge N → CHECK in cycle N+1 → OPEN, DENY or LOCKOUT in cycle N+2.
- Outputs are registered; cmp_en, unlocked, denied and alarm are pure decodes of the state register.
- guess_out holds its value until the next accepted submit.
- Reset asserted in any state returns immediately to the reset values. The stored code is cleared, so the controller needs a new set request.

Test Plan:
- Reset, set_code=4'b1010, set_btn pulse → state=ARMED, code_out=4'hA, tries_left=3; submit in EMPTY before the set has no effect.
- Armed with 4'hA, guess=4'hA, submit pulse → cmp_en high exactly one cycle (N+1), unlocked high cycles N+2..N+9 (8 cycles), then ARMED.
- Armed with 4'hA, three submits of guess=4'h5 (comparator mismatches) → denied pulses twice, tries_left 3→2→1→0, third failure enters LOCKOUT with alarm high 16 cycles. A submit of 4'hA during lockout is ignored, giving no cmp_en. Afterwards state=ARMED, tries_left=3.
- In OPEN, set_code=4'h3 with set_btn pulse → code_out=4'h3, ARMED immediately. A subsequent guess 4'hA fails and guess 4'h3 opens.
- submit_btn held high 10 cycles in ARMED → exactly one CHECK; simultaneous set and submit edges in ARMED → CHECK taken, code unchanged.
- rst_n low asynchronously mid-LOCKOUT and mid-OPEN → all outputs at reset values before the next clock, state=EMPTY, code_out=0.
